// File: rtl/icache_direct.sv
// Purpose : direct-mapped, one-word-per-frame instruction cache between fetch and the memory controller.
// Latency : a hit returns data in the request cycle; a miss takes controller wait cycles + 2.
// Backpres: ihit low stalls fetch; a fill holds iREN/iaddr steady while the controller drives iwait high.
module icache_direct #(
    parameter int NFRAMES = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    input  logic        flush
);
    localparam int IDXW = $clog2(NFRAMES);
    localparam int TAGW = 30 - IDXW;

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    state_t            r_state;
    logic [29:0]       r_miss_waddr;
    logic [NFRAMES-1:0] r_valid;
    logic [TAGW-1:0]   r_tag  [NFRAMES];
    logic [31:0]       r_data [NFRAMES];

    logic [IDXW-1:0]   w_idx;
    logic [TAGW-1:0]   w_tag;
    logic [IDXW-1:0]   w_miss_idx;
    logic [TAGW-1:0]   w_miss_tag;
    logic              w_lookup;
    logic              w_hit;
    logic              w_unused_byte_offset;

    // Byte offset inside the word carries no information for a word cache.
    assign w_unused_byte_offset = ^imemaddr[1:0];

    assign w_idx      = imemaddr[IDXW+1:2];
    assign w_tag      = imemaddr[31:IDXW+2];
    assign w_miss_idx = r_miss_waddr[IDXW-1:0];
    assign w_miss_tag = r_miss_waddr[29:IDXW];

    // Tag compare against the frame selected by the live request address.
    assign w_lookup = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // Hits are served only from IDLE, and a flush cycle never reports a hit.
    assign w_hit    = (r_state == IDLE) && imemREN && w_lookup && !flush;
    assign ihit     = w_hit;
    assign imemload = w_hit ? r_data[w_idx] : 32'h0;

    // Controller request is a pure decode of the state register: no path from iwait/iload.
    assign iREN  = (r_state == FILL);
    assign iaddr = (r_state == FILL) ? {r_miss_waddr, 2'b00} : 32'h0;

    // FSM, miss-address latch and frame array; flush outranks both miss detection and fill write.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_miss_waddr <= '0;
            r_valid      <= '0;
            for (int i = 0; i < NFRAMES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (imemREN && !w_lookup) begin
                        r_miss_waddr <= imemaddr[31:2];
                        r_state      <= FILL;
                    end
                end
                FILL: begin
                    if (!iwait) begin
                        r_valid[w_miss_idx] <= 1'b1;
                        r_tag[w_miss_idx]   <= w_miss_tag;
                        r_data[w_miss_idx]  <= iload;
                        r_state             <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// Purpose : directed stimulus for icache_direct with a per-cycle expected-output scoreboard.
// Latency : stimulus pushes one expectation per cycle; the monitor checks it half a cycle later.
// Backpres: the bench plays the memory controller and drives iwait directly.
module tb_icache_direct;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = 32'h0;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait = 1'b1;
    logic [31:0] iload = 32'h0;
    logic        flush = 1'b0;

    typedef struct {
        logic        hit;
        logic [31:0] load;
        logic        ren;
        logic [31:0] ia;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    icache_direct #(.NFRAMES(16)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .flush    (flush)
    );

    always #5 CLK = ~CLK;

    // Drive one cycle of inputs just after the rising edge and queue what the outputs must be.
    task automatic step(input string nm, input logic rst, input logic ren, input logic [31:0] addr,
                        input logic iw, input logic [31:0] ld, input logic fl,
                        input logic e_hit, input logic [31:0] e_load,
                        input logic e_ren, input logic [31:0] e_ia);
        exp_t e;
        @(posedge CLK);
        #1;
        nRST     = rst;
        imemREN  = ren;
        imemaddr = addr;
        iwait    = iw;
        iload    = ld;
        flush    = fl;
        e.hit  = e_hit;
        e.load = e_load;
        e.ren  = e_ren;
        e.ia   = e_ia;
        e.nm   = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: mid-cycle, compare every output against the oldest pending expectation.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if ({ihit, imemload, iREN, iaddr} !== {e.hit, e.load, e.ren, e.ia}) begin
                n_bad++;
                $display("FAIL %s: got ihit=%b imemload=%h iREN=%b iaddr=%h, want ihit=%b imemload=%h iREN=%b iaddr=%h",
                         e.nm, ihit, imemload, iREN, iaddr, e.hit, e.load, e.ren, e.ia);
            end
        end
    end

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    initial begin
        // Reset state
        step("reset",        0, 0, 32'h0,  1, JUNK, 0,  0, 32'h0, 0, 32'h0);
        step("reset_req",    0, 1, 32'h0,  1, JUNK, 0,  0, 32'h0, 0, 32'h0);

        // 1: cold miss on 0x0 with three controller wait cycles
        step("t1_miss",      1, 1, 32'h0,  1, JUNK, 0,  0, 32'h0, 0, 32'h0);
        step("t1_wait1",     1, 1, 32'h0,  1, JUNK, 0,  0, 32'h0, 1, 32'h0);
        step("t1_wait2",     1, 1, 32'h0,  1, JUNK, 0,  0, 32'h0, 1, 32'h0);
        step("t1_wait3",     1, 1, 32'h0,  1, JUNK, 0,  0, 32'h0, 1, 32'h0);
        step("t1_fill",      1, 1, 32'h0,  0, 32'h2001_0005, 0,  0, 32'h0, 1, 32'h0);
        step("t1_hit",       1, 1, 32'h0,  1, JUNK, 0,  1, 32'h2001_0005, 0, 32'h0);
        step("t1_rehit",     1, 1, 32'h0,  1, JUNK, 0,  1, 32'h2001_0005, 0, 32'h0);
        step("t1_idle",      1, 0, 32'h0,  1, JUNK, 0,  0, 32'h0, 0, 32'h0);

        // 2: conflict on index 0 between tag 0 and tag 1
        step("t2_miss40",    1, 1, 32'h40, 1, JUNK, 0,  0, 32'h0, 0, 32'h0);
        step("t2_fill40",    1, 1, 32'h40, 0, 32'hAAAA_0001, 0,  0, 32'h0, 1, 32'h40);
        step("t2_hit40",     1, 1, 32'h40, 1, JUNK, 0,  1, 32'hAAAA_0001, 0, 32'h0);
        step("t2_miss0",     1, 1, 32'h0,  1, JUNK, 0,  0, 32'h0, 0, 32'h0);
        step("t2_fill0",     1, 1, 32'h0,  0, 32'h2001_0005, 0,  0, 32'h0, 1, 32'h0);
        step("t2_hit0",      1, 1, 32'h0,  1, JUNK, 0,  1, 32'h2001_0005, 0, 32'h0);
        step("t2_miss40b",   1, 1, 32'h40, 1, JUNK, 0,  0, 32'h0, 0, 32'h0);
        step("t2_fill40b",   1, 1, 32'h40, 0, 32'hAAAA_0001, 0,  0, 32'h0, 1, 32'h40);

        // 3: two neighbouring frames hit back to back
        step("t3_miss4",     1, 1, 32'h4,  1, JUNK, 0,  0, 32'h0, 0, 32'h0);
        step("t3_fill4",     1, 1, 32'h4,  0, 32'h1111_1111, 0,  0, 32'h0, 1, 32'h4);
        step("t3_miss8",     1, 1, 32'h8,  1, JUNK, 0,  0, 32'h0, 0, 32'h0);
        step("t3_fill8",     1, 1, 32'h8,  0, 32'h2222_2222, 0,  0, 32'h0, 1, 32'h8);
        for (int i = 0; i < 4; i++) begin
            step("t3_alt4",  1, 1, 32'h4,  1, JUNK, 0,  1, 32'h1111_1111, 0, 32'h0);
            step("t3_alt8",  1, 1, 32'h8,  1, JUNK, 0,  1, 32'h2222_2222, 0, 32'h0);
        end
        step("t3_hit40",     1, 1, 32'h40, 1, JUNK, 0,  1, 32'hAAAA_0001, 0, 32'h0);

        // 4: address changes and imemREN drops while a fill is in flight
        step("t4_miss10",    1, 1, 32'h10, 1, JUNK, 0,  0, 32'h0, 0, 32'h0);
        step("t4_wait",      1, 1, 32'h10, 1, JUNK, 0,  0, 32'h0, 1, 32'h10);
        step("t4_addrchg",   1, 1, 32'h20, 1, JUNK, 0,  0, 32'h0, 1, 32'h10);
        step("t4_fill10",    1, 1, 32'h20, 0, 32'h4444_4444, 0,  0, 32'h0, 1, 32'h10);
        step("t4_miss20",    1, 1, 32'h20, 1, JUNK, 0,  0, 32'h0, 0, 32'h0);
        step("t4_renoff",    1, 0, 32'h20, 1, JUNK, 0,  0, 32'h0, 1, 32'h20);
        step("t4_fill20",    1, 0, 32'h20, 0, 32'h5555_5555, 0,  0, 32'h0, 1, 32'h20);
        step("t4_hit10",     1, 1, 32'h10, 1, JUNK, 0,  1, 32'h4444_4444, 0, 32'h0);
        step("t4_hit20",     1, 1, 32'h20, 1, JUNK, 0,  1, 32'h5555_5555, 0, 32'h0);

        // 5: flush on the completing fill cycle discards the fill and invalidates everything
        step("t5_miss30",    1, 1, 32'h30, 1, JUNK, 0,  0, 32'h0, 0, 32'h0);
        step("t5_wait",      1, 1, 32'h30, 1, JUNK, 0,  0, 32'h0, 1, 32'h30);
        step("t5_flushfill", 1, 1, 32'h30, 0, 32'h6666_6666, 1,  0, 32'h0, 1, 32'h30);
        step("t5_miss30b",   1, 1, 32'h30, 1, JUNK, 0,  0, 32'h0, 0, 32'h0);
        step("t5_fill30",    1, 1, 32'h30, 0, 32'h1234_0030, 0,  0, 32'h0, 1, 32'h30);
        step("t5_hit30",     1, 1, 32'h30, 1, JUNK, 0,  1, 32'h1234_0030, 0, 32'h0);
        step("t5_miss8",     1, 1, 32'h8,  1, JUNK, 0,  0, 32'h0, 0, 32'h0);
        step("t5_fill8",     1, 1, 32'h8,  0, 32'h2222_2222, 0,  0, 32'h0, 1, 32'h8);
        step("t5_hit8",      1, 1, 32'h8,  1, JUNK, 0,  1, 32'h2222_2222, 0, 32'h0);
        step("t5_flushhit",  1, 1, 32'h8,  1, JUNK, 1,  0, 32'h0, 0, 32'h0);
        step("t5_miss8b",    1, 1, 32'h8,  1, JUNK, 0,  0, 32'h0, 0, 32'h0);
        step("t5_fill8b",    1, 1, 32'h8,  0, 32'h2222_2222, 0,  0, 32'h0, 1, 32'h8);
        step("t5_miss10",    1, 1, 32'h10, 1, JUNK, 0,  0, 32'h0, 0, 32'h0);
        step("t5_fill10",    1, 1, 32'h10, 0, 32'h4444_4444, 0,  0, 32'h0, 1, 32'h10);

        // 6: asynchronous reset while a fill is waiting on the controller
        step("t6_hit10",     1, 1, 32'h10, 1, JUNK, 0,  1, 32'h4444_4444, 0, 32'h0);
        step("t6_miss4",     1, 1, 32'h4,  1, JUNK, 0,  0, 32'h0, 0, 32'h0);
        step("t6_wait",      1, 1, 32'h4,  1, JUNK, 0,  0, 32'h0, 1, 32'h4);
        step("t6_rst",       0, 1, 32'h4,  1, JUNK, 0,  0, 32'h0, 0, 32'h0);
        step("t6_miss10",    1, 1, 32'h10, 1, JUNK, 0,  0, 32'h0, 0, 32'h0);
        step("t6_fill10",    1, 1, 32'h10, 0, 32'h4444_4444, 0,  0, 32'h0, 1, 32'h10);
        step("t6_hit10b",    1, 1, 32'h10, 1, JUNK, 0,  1, 32'h4444_4444, 0, 32'h0);
        step("t6_end",       1, 0, 32'h0,  1, JUNK, 0,  0, 32'h0, 0, 32'h0);

        // Drain: every queued expectation must have been checked within a bounded time.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge CLK);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
